// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and helpers for the 16:1 mux scan controller.
// Provides the FSM state enum, channel-count / select-width constants and
// the next_set_bit() search used by the priority encoder.
package mux_scan_pkg;

  localparam int N_CH  = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } srch_t;

  // Lowest set bit of mask whose index is >= lo. lo is one bit wider than a
  // select so that "above channel 15" (lo = 16) reports not-found.
  function automatic srch_t next_set_bit(input logic [N_CH-1:0] mask,
                                         input logic [SEL_W:0]  lo);
    srch_t r;
    r = '0;
    // Walk downwards so the last hit, i.e. the lowest index, wins.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(lo))) begin
        r.found = 1'b1;
        r.idx   = i[SEL_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_prienc.sv
// Masked priority encoder: lowest set bit of mask at index >= lo.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
// Ports: mask (channel enables), lo (search floor, 0..16),
//        found (a channel exists), idx (its index, valid when found).
module mux_scan_prienc
  import mux_scan_pkg::*;
(
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W:0]   lo,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  srch_t res;

  always_comb begin
    res = next_set_bit(mask, lo);
  end

  assign found = res.found;
  assign idx   = res.idx;

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller: walks the 16:1 mux select over enabled channels, settles, samples.
// Latency: start-to-done 1 + n_enabled*(SETTLE_CYC+1) cycles, done is a 1-cycle pulse.
// Backpressure: start is only honoured in IDLE (and DONE with MUX_SCAN_AUTO_RESTART_EN); others dropped.
// Ports: clk/rst_n (async active-low), start, ch_mask (latched on accept), mux_o (mux output bit),
//        sel (mux select), busy, done, sample_vec (bit i = mux_o seen with sel=i).
// Optional macro MUX_SCAN_AUTO_RESTART_EN: a start held high in DONE relaunches without visiting IDLE.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_CH-1:0]  ch_mask,
  input  logic             mux_o,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             done,
  output logic [N_CH-1:0]  sample_vec
);

  // Last settle count before sampling; unused when SETTLE_CYC is 0.
  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);
  // With no settle time a channel goes straight to SAMPLE.
  localparam state_t CH_ENTRY = (SETTLE_CYC == 0) ? ST_SAMPLE : ST_SETTLE;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [N_CH-1:0]   mask_q, mask_d;
  logic [N_CH-1:0]   vec_q, vec_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              busy_q, done_q;
  logic              launch;

  logic              first_found, nxt_found;
  logic [SEL_W-1:0]  first_idx, nxt_idx;
  logic [SEL_W:0]    nxt_lo;

  // First channel comes from the live mask (it is latched on the same edge);
  // subsequent channels come from the latched copy, strictly above sel.
  assign nxt_lo = {1'b0, sel_q} + {{SEL_W{1'b0}}, 1'b1};

  mux_scan_prienc u_first (
    .mask  (ch_mask),
    .lo    ('0),
    .found (first_found),
    .idx   (first_idx)
  );

  mux_scan_prienc u_next (
    .mask  (mask_q),
    .lo    (nxt_lo),
    .found (nxt_found),
    .idx   (nxt_idx)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    launch  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        launch = start;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_SAMPLE: begin
        vec_d[sel_q] = mux_o;
        if (nxt_found) begin
          sel_d   = nxt_idx;
          cnt_d   = '0;
          state_d = CH_ENTRY;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef MUX_SCAN_AUTO_RESTART_EN
        launch = start;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Accepted start: latch mask, drop old results, jump to first channel.
    // An empty mask still completes, but without ever raising busy.
    if (launch) begin
      mask_d = ch_mask;
      vec_d  = '0;
      cnt_d  = '0;
      if (first_found) begin
        sel_d   = first_idx;
        state_d = CH_ENTRY;
      end else begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      mask_q  <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      // Flags are registered decodes of the next state so they line up
      // exactly with the state they describe.
      busy_q  <= (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign sel        = sel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sample_vec = vec_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (settle 1 and settle 0) share start/ch_mask
// and each sees its own mux output bit selected from a common 16-bit input word.
// Expected scans are queued when a start is accepted; a negedge monitor checks them.
module tb_mux_scan_ctrl;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [15:0]      ch_mask;
  logic [15:0]      in_vec;

  logic [1:0][3:0]  sel_a;
  logic [1:0]       busy_a, done_a, mux_a;
  logic [1:0][15:0] vec_a;

  typedef struct {
    int          d;
    logic [15:0] vec;
    logic [15:0] mask;
  } exp_t;

  exp_t       q0[$], q1[$];
  logic [3:0] tr0[$], tr1[$];
  int         cyc, n_checks, n_err;
  int         free_at[2];

  always #5 clk = ~clk;

  assign mux_a[0] = in_vec[sel_a[0]];
  assign mux_a[1] = in_vec[sel_a[1]];

  mux_scan_ctrl #(.SETTLE_CYC(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_mask(ch_mask), .mux_o(mux_a[0]),
    .sel(sel_a[0]), .busy(busy_a[0]), .done(done_a[0]), .sample_vec(vec_a[0])
  );

  mux_scan_ctrl #(.SETTLE_CYC(0)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_mask(ch_mask), .mux_o(mux_a[1]),
    .sel(sel_a[1]), .busy(busy_a[1]), .done(done_a[1]), .sample_vec(vec_a[1])
  );

  function automatic int settle_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cyc=%0d: got 0x%0h expected 0x%0h", nm, k, cyc, act, exp);
    end
  endtask

  // Reference: a scan over n enabled channels ends n*(settle+1)+1 cycles after
  // the start cycle, and returns exactly the input bits selected by the mask.
  task automatic accept(input int k, input logic [15:0] m);
    exp_t e;
    e.d    = cyc + 1 + $countones(m) * (settle_of(k) + 1);
    e.vec  = in_vec & m;
    e.mask = m;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
`ifdef MUX_SCAN_AUTO_RESTART_EN
    free_at[k] = e.d;
`else
    free_at[k] = e.d + 1;
`endif
  endtask

  task automatic tick(input logic s, input logic [15:0] m);
    start   = s;
    ch_mask = m;
    if (s) begin
      for (int k = 0; k < 2; k++) if (cyc >= free_at[k]) accept(k, m);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((cyc < free_at[0] || cyc < free_at[1]) && g < 3000) begin
      tick(1'b0, 16'($urandom));
      g++;
    end
    tick(1'b0, 16'h0);
  endtask

  task automatic mon(input int k);
    exp_t       e;
    logic [3:0] tr[$];
    logic [3:0] want[$];
    int         bad;
    bit         has;
    if (busy_a[k]) begin
      if (k == 0) tr0.push_back(sel_a[k]); else tr1.push_back(sel_a[k]);
    end
    has = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (has) begin
      if (k == 0) e = q0[0]; else e = q1[0];
    end
    if (done_a[k]) begin
      if (!has) begin
        n_checks++;
        n_err++;
        $display("FAIL spurious_done dut%0d cyc=%0d: got done=1 expected done=0", k, cyc);
      end else begin
        chk("done_cycle", k, cyc, e.d);
        chk("sample_vec", k, vec_a[k], e.vec);
        chk("busy_at_done", k, busy_a[k], 0);
        if (k == 0) tr = tr0; else tr = tr1;
        for (int i = 0; i < 16; i++)
          if (e.mask[i]) for (int r = 0; r <= settle_of(k); r++) want.push_back(4'(i));
        chk("sel_trace_len", k, tr.size(), want.size());
        bad = 0;
        for (int i = 0; i < tr.size() && i < want.size(); i++) if (tr[i] !== want[i]) bad++;
        chk("sel_trace_bad", k, bad, 0);
        if (k == 0) begin void'(q0.pop_front()); tr0.delete(); end
        else        begin void'(q1.pop_front()); tr1.delete(); end
      end
    end else if (has && cyc > e.d) begin
      n_checks++;
      n_err++;
      $display("FAIL done_timeout dut%0d cyc=%0d: got no done expected done at cyc %0d", k, cyc, e.d);
      if (k == 0) begin void'(q0.pop_front()); tr0.delete(); end
      else        begin void'(q1.pop_front()); tr1.delete(); end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int k = 0; k < 2; k++) mon(k);
    end
  end

  task automatic check_reset_outputs();
    for (int k = 0; k < 2; k++) begin
      chk("rst_sel", k, sel_a[k], 0);
      chk("rst_busy", k, busy_a[k], 0);
      chk("rst_done", k, done_a[k], 0);
      chk("rst_vec", k, vec_a[k], 0);
    end
  endtask

  // Asynchronous reset asserted mid-cycle; pending scans are abandoned.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    start = 1'b0;
    q0.delete(); q1.delete(); tr0.delete(); tr1.delete();
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    free_at[0] = cyc;
    free_at[1] = cyc;
  endtask

  initial begin
    rst_n      = 1'b1;
    start      = 1'b0;
    ch_mask    = '0;
    in_vec     = '0;
    cyc        = 0;
    n_checks   = 0;
    n_err      = 0;
    free_at[0] = 0;
    free_at[1] = 0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Full mask with a known input pattern.
    in_vec = 16'hA5C3;
    tick(1'b1, 16'hFFFF);
    wait_idle();

    // Sparse mask: only channels 0, 8, 15.
    in_vec = 16'hFFFF;
    tick(1'b1, 16'h8101);
    wait_idle();

    // Empty mask: immediate done, busy never raised.
    in_vec = 16'h1234;
    tick(1'b1, 16'h0000);
    wait_idle();

    // Re-start and mask cleared mid-scan must not disturb the running scan.
    in_vec = 16'($urandom);
    tick(1'b1, 16'hFFFF);
    repeat (4) tick(1'b0, 16'hFFFF);
    tick(1'b1, 16'h0000);
    wait_idle();

    // Reset at cycle 10 of a full scan, then a clean scan.
    in_vec = 16'hFFFF;
    tick(1'b1, 16'hFFFF);
    repeat (9) tick(1'b0, 16'hFFFF);
    mid_reset();
    in_vec = 16'h5AA5;
    tick(1'b1, 16'hFFFF);
    wait_idle();

    // Start held high across several scans (back-to-back with auto restart).
    in_vec = 16'($urandom);
    repeat (75) tick(1'b1, 16'hFFFF);
    wait_idle();

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      logic [15:0] m;
      case ($urandom_range(0, 3))
        0:       m = 16'hFFFF;
        1:       m = 16'h0000;
        2:       m = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
        default: m = 16'($urandom);
      endcase
      if (cyc >= free_at[0] && cyc >= free_at[1] && $urandom_range(0, 3) == 0)
        in_vec = 16'($urandom);
      tick($urandom_range(0, 2) == 0, m);
    end
    wait_idle();
    repeat (3) tick(1'b0, 16'h0);

    chk("pending_scans", 0, q0.size(), 0);
    chk("pending_scans", 1, q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
